// File: rtl/counter0_7.sv
// Modulo-(MAX_COUNT+1) up-counter with synchronous clear.
// The terminal-count flag is a divide-by-8 tick for the next timing stage.
module counter0_7 #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7
) (
  input  logic clk,
  input  logic clear,
  output logic out
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count;
  logic             at_tc;

  assign at_tc = (count == TC);

  // Clear wins over the wrap, so a clear at terminal count gives no extra tick
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (at_tc) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign out = at_tc;

endmodule

// File: tb/tb_counter0_7.sv
// Scoreboard bench for counter0_7.
// Directed clear/run segments; a monitor compares each cycle.
module tb_counter0_7;

  logic clk;
  logic clear;
  logic out;

  counter0_7 dut (
    .clk   (clk),
    .clear (clear),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int       step;
    logic [2:0] cnt;
    logic     tc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;
  int   since = 0;
  int   highs = 0;

  // Expected values: edges elapsed since the last sampled clear, mod 8.
  task automatic drive(input logic c, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      clear = c;
      @(posedge clk);
      #1;
      if (c) since = 0;
      else since = since + 1;
      e.step = step;
      e.cnt  = 3'(since % 8);
      e.tc   = ((since % 8) == 7);
      q.push_back(e);
      step = step + 1;
    end
  endtask

  // Clear pulse that falls entirely between rising edges
  task automatic glitch_cycle();
    exp_t e;
    clear = 1'b0;
    @(negedge clk);
    #1 clear = 1'b1;
    #2 clear = 1'b0;
    @(posedge clk);
    #1;
    since = since + 1;
    e.step = step;
    e.cnt  = 3'(since % 8);
    e.tc   = ((since % 8) == 7);
    q.push_back(e);
    step = step + 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total = total + 1;
      if (out !== e.tc) begin
        bad = bad + 1;
        $display("FAIL out step=%0d got=%b want=%b",
                 e.step, out, e.tc);
      end
      total = total + 1;
      if (dut.count !== e.cnt) begin
        bad = bad + 1;
        $display("FAIL count step=%0d got=%0d want=%0d",
                 e.step, dut.count, e.cnt);
      end
      if (out === 1'b1) highs = highs + 1;
    end
  end

  initial begin
    int h0;
    clear = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 7);
    drive(1'b0, 1);
    // 24 free-running cycles: exactly three ticks
    h0 = highs;
    drive(1'b0, 24);
    @(negedge clk);
    #1;
    total = total + 1;
    if (highs - h0 != 3) begin
      bad = bad + 1;
      $display("FAIL period24 got=%0d want=3", highs - h0);
    end
    drive(1'b0, 13);
    drive(1'b1, 12);
    drive(1'b0, 9);
    drive(1'b1, 1);
    drive(1'b0, 4);
    drive(1'b1, 1);
    drive(1'b0, 9);
    drive(1'b1, 1);
    drive(1'b0, 7);
    drive(1'b1, 1);
    drive(1'b0, 8);
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1);
      drive(1'b0, 11);
    end
    drive(1'b1, 1);
    drive(1'b0, 3);
    glitch_cycle();
    glitch_cycle();
    drive(1'b0, 6);
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
